dec_ascii_tx: RTL and testbench
===============================

DEC_ASCII_TX -- requirements
Module: dec_ascii_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning bit width of the binary value to transmit.
REQ-002 The block SHALL have parameter DIGITS, default 20, meaning BCD digit count, sized to hold 2^WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port value  input  WIDTH  unsigned binary result to transmit, sampled only when start is accepted.
REQ-006 The block SHALL have port start  input  1  request to transmit value.
REQ-007 The block SHALL have port charOut  output  8  ASCII decimal digit, 0x30-0x39.
REQ-008 The block SHALL have port charOutValid  output  1  charOut holds a digit this cycle; no backpressure, the sink must take it.
REQ-009 The block SHALL have port done  output  1  transmission complete.
REQ-010 The block SHALL have port busy  output  1  conversion or emission in progress.

Function
REQ-011 The block SHALL implement states IDLE, CONVERT, EMIT, DONE; all outputs SHALL be registered.
REQ-012 start SHALL be accepted on a rising edge (E0) only in IDLE or DONE; at E0 value is latched, the BCD register is cleared, done drops to 0, busy rises to 1, and the state becomes CONVERT.
REQ-013 start in CONVERT or EMIT SHALL be ignored, with no effect on value, outputs or timing.
REQ-014 CONVERT SHALL perform one double-dabble step per edge (add 3 to every BCD nibble >= 5, then shift left one bit, taking the MSB of the latched value) for exactly WIDTH edges (E1..E_WIDTH); the state then becomes EMIT.
REQ-015 EMIT SHALL visit exactly one digit position per edge, most significant first, for DIGITS edges (E_WIDTH+1..E_WIDTH+DIGITS).
REQ-016 At each EMIT edge, if the digit is nonzero, or a nonzero digit has already been emitted, or it is the least significant position, the block SHALL register charOut = 0x30 + digit and charOutValid = 1; otherwise it SHALL register charOutValid = 0.
REQ-017 Leading zeros SHALL never be emitted; value 0 SHALL emit exactly one "0".
REQ-018 At edge E_WIDTH+DIGITS+1 the block SHALL register charOutValid = 0, busy = 0 and done = 1, and the state becomes DONE.
REQ-019 Latency SHALL be fixed and independent of value: done rises WIDTH+DIGITS+1 edges after E0 (85 for the defaults).
REQ-020 done SHALL hold at 1 in DONE until the next accepted start or reset.
REQ-021 charOut SHALL hold its last value while charOutValid = 0; its content is meaningless then.
REQ-022 The block SHALL emit between 1 and DIGITS characters per transmission, with no gaps between non-leading digits.

Reset
REQ-023 rst = 1 SHALL immediately, without waiting for a clock edge, force the state to IDLE, charOut = 0x00, charOutValid = 0, done = 0, busy = 0, and clear the latched value and the BCD register.
REQ-024 Reset asserted mid-CONVERT or mid-EMIT SHALL abort the transmission with no further characters emitted.
REQ-025 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-026 value = 357, start 1 cycle -> exactly "3","5","7" on consecutive valid cycles after edges E82..E84; done = 1 after E85.
REQ-027 value = 3121910778619 -> exactly the 13 characters "3121910778619" in order; done after E85.
REQ-028 value = 0 -> exactly one "0" (valid only after E84); value = 2^64-1 -> the 20 characters "18446744073709551615".
REQ-029 start pulsed again during CONVERT and during EMIT with a different value -> output identical to the undisturbed run; a second start in DONE -> a new transmission, done = 0 after that edge.
REQ-030 rst asserted between two emitted digits -> outputs cleared immediately, no further valid characters, done stays 0; a subsequent start with 42 -> "4","2", done.
REQ-031 The bench SHALL check every cycle that charOut is within 0x30-0x39 when charOutValid = 1, that busy and done are never both 1, and that no leading "0" appears.

Source files
------------

// File: rtl/dec_ascii_tx_if.sv
// Handshake bundle between a result producer and the decimal ASCII serializer.
interface dec_ascii_tx_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] value;
    logic             start;
    logic [7:0]       charOut;
    logic             charOutValid;
    logic             done;
    logic             busy;

    modport master (
        output value, start,
        input  charOut, charOutValid, done, busy
    );

    modport slave (
        input  value, start,
        output charOut, charOutValid, done, busy
    );
endinterface

// File: rtl/dec_ascii_tx.sv
// Binary-to-ASCII decimal serializer (double-dabble, leading zeros suppressed), MSD first.
// Latency WIDTH+DIGITS+1 cycles from accepted start to done; no backpressure, sink takes every valid char.
module dec_ascii_tx #(
    parameter int WIDTH  = 64,
    parameter int DIGITS = 20
) (
    input  logic          clk,
    input  logic          rst,
    dec_ascii_tx_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, EMIT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] valReg;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcdAdj;
    logic [CW-1:0]    bitCnt;
    logic [DW-1:0]    digCnt;
    logic             seen;
    logic [3:0]       digit;
    logic [7:0]       charReg;
    logic             validReg;
    logic             doneReg;
    logic             busyReg;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcdAdj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign digit = bcd[BW-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valReg   <= '0;
            bcd      <= '0;
            bitCnt   <= '0;
            digCnt   <= '0;
            seen     <= 1'b0;
            charReg  <= 8'h00;
            validReg <= 1'b0;
            doneReg  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        valReg   <= bus.value;
                        bcd      <= '0;
                        bitCnt   <= '0;
                        doneReg  <= 1'b0;
                        busyReg  <= 1'b1;
                        validReg <= 1'b0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd    <= {bcdAdj[BW-2:0], valReg[WIDTH-1]};
                    valReg <= valReg << 1;
                    bitCnt <= bitCnt + 1'b1;
                    if (bitCnt == CW'(WIDTH - 1)) begin
                        digCnt <= '0;
                        seen   <= 1'b0;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (digCnt == DW'(DIGITS)) begin
                        validReg <= 1'b0;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        // Top nibble is the current digit; shift the next one up.
                        bcd    <= bcd << 4;
                        digCnt <= digCnt + 1'b1;
                        if (digit != 4'd0 || seen || digCnt == DW'(DIGITS - 1)) begin
                            charReg  <= 8'h30 + {4'h0, digit};
                            validReg <= 1'b1;
                            seen     <= 1'b1;
                        end else begin
                            validReg <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.charOut      = charReg;
    assign bus.charOutValid = validReg;
    assign bus.done         = doneReg;
    assign bus.busy         = busyReg;
endmodule

// File: tb/tb_dec_ascii_tx.sv
// Directed bench for dec_ascii_tx: fixed-latency decimal serialization, start filtering and async reset abort.
module tb_dec_ascii_tx;
    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    string rxStr;
    int    validEdges[$];
    int    doneEdge;
    int    cnt;

    always #5 clk = ~clk;

    dec_ascii_tx_if #(.WIDTH(64)) bus ();

    dec_ascii_tx #(.WIDTH(64), .DIGITS(20)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkStr(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    // Per-cycle invariants.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busyDoneExclusive", {63'd0, bus.busy & bus.done}, 64'd0);
            if (bus.charOutValid) begin
                chk("charInRange", {63'd0, (bus.charOut >= 8'h30 && bus.charOut <= 8'h39)}, 64'd1);
            end
        end
    end

    // Start a transmission of v; optionally pulse start with dv before edges dA and dB.
    task automatic runTx(input logic [63:0] v, input bit noWait, input int dA, input int dB,
                         input logic [63:0] dv);
        rxStr = "";
        validEdges.delete();
        doneEdge = -1;
        if (!noWait) @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = ~v;
        chk("busyAfterE0", {63'd0, bus.busy}, 64'd1);
        chk("doneAfterE0", {63'd0, bus.done}, 64'd0);
        for (int n = 1; n <= 100 && doneEdge < 0; n++) begin
            if (n == dA || n == dB) begin
                bus.start = 1'b1;
                bus.value = dv;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.charOutValid) begin
                chk("noLeadingZero", {63'd0, rxStr == "0"}, 64'd0);
                rxStr = $sformatf("%s%c", rxStr, bus.charOut);
                validEdges.push_back(n);
            end
            if (bus.done && doneEdge < 0) doneEdge = n;
        end
    endtask

    task automatic checkTx(input string tag, input string exp);
        int first;
        int last;
        first = (validEdges.size() > 0) ? validEdges[0] : -1;
        last  = (validEdges.size() > 0) ? validEdges[validEdges.size()-1] : -1;
        chkStr({tag, "_chars"}, rxStr, exp);
        chk({tag, "_doneEdge"}, 64'(doneEdge), 64'd85);
        chk({tag, "_firstEdge"}, 64'(first), 64'(85 - exp.len()));
        chk({tag, "_lastEdge"}, 64'(last), 64'd84);
        chk({tag, "_noGaps"}, 64'(last - first + 1), 64'(validEdges.size()));
        chk({tag, "_busyEnd"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_validEnd"}, {63'd0, bus.charOutValid}, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.value = '0;
        #1;
        chk("rst_charOut", {56'd0, bus.charOut}, 64'h00);
        chk("rst_valid", {63'd0, bus.charOutValid}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Start on the first edge after reset release.
        runTx(64'd357, 1'b1, 0, 0, '0);
        checkTx("v357", "357");

        repeat (3) @(negedge clk);
        chk("doneHolds", {63'd0, bus.done}, 64'd1);

        runTx(64'd3121910778619, 1'b0, 0, 0, '0);
        checkTx("v13dig", "3121910778619");

        runTx(64'd0, 1'b0, 0, 0, '0);
        checkTx("vZero", "0");

        runTx(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, '0);
        checkTx("vMax", "18446744073709551615");

        runTx(64'd357, 1'b0, 10, 75, 64'd999);
        checkTx("vIgnoreStart", "357");

        // Abort with reset between the first and second emitted digit.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 64'd357;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (82) @(posedge clk);
        #1;
        chk("abort_firstValid", {63'd0, bus.charOutValid}, 64'd1);
        chk("abort_firstChar", {56'd0, bus.charOut}, 64'h33);
        #2 rst = 1'b1;
        #1;
        chk("abort_charOut", {56'd0, bus.charOut}, 64'h00);
        chk("abort_valid", {63'd0, bus.charOutValid}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.charOutValid || bus.done) cnt++;
        end
        chk("abort_quiet", 64'(cnt), 64'd0);

        runTx(64'd42, 1'b0, 0, 0, '0);
        checkTx("v42", "42");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
